// File: rtl/fp_adder_pipe.sv
// fp_adder_pipe: pipelined IEEE-754 adder (capture, align, add/normalise, round/pack) with valid/ready.
// Build option: define FP_ADDER_PIPE_SUB_OP_EN to add the op_sub port (computes a - b when set).
module fp_adder_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] fp_a,
    input  logic [EXP_W+MAN_W:0] fp_b,
    input  logic [2:0]           r_mode,
`ifdef FP_ADDER_PIPE_SUB_OP_EN
    input  logic                 op_sub,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] fp_result,
    output logic                 overflow,
    output logic                 underflow,
    output logic                 invalid,
    output logic                 inexact
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int M  = MAN_W + 4;
    localparam int E1 = EXP_W + 1;
    localparam logic [EXP_W-1:0] EMAX = '1;

    // Handshake: a transfer happens on an edge where valid & ready are both high. The whole
    // pipeline moves only when the output register is empty or being drained (adv); bubbles keep their slot.
    logic adv;
    assign adv      = !out_valid | out_ready;
    assign in_ready = adv;

    logic [W-1:0] b_eff;
`ifdef FP_ADDER_PIPE_SUB_OP_EN
    assign b_eff = {fp_b[W-1] ^ op_sub, fp_b[W-2:0]};
`else
    assign b_eff = fp_b;
`endif

    // Stage registers: capture (0), aligned (1), normalised (2), rounded output.
    logic v0, v1, v2;
    logic [W-1:0] a0, b0;
    logic [2:0] rm0, s1_rm, s2_rm;
    logic s1_sx, s1_sy, s1_spec, s1_inv, s2_sign, s2_spec, s2_inv;
    logic [EXP_W-1:0] s1_exp;
    logic [M-1:0] s1_mx, s1_my, s2_m;
    logic [E1-1:0] s2_exp;
    logic [W-1:0] s1_val, s2_val;

    // S1: classify, swap so x has the larger magnitude, align y with sticky collapse.
    logic a_inf, b_inf, a_nan, b_nan, inf_clash, spec_n, inv_n1, swap;
    logic [W-1:0] val_n, x, y;
    logic [EXP_W-1:0] ex, ey, d;
    logic [M-1:0] mx, my, my_al;
    logic [2*M-1:0] wide;
    always_comb begin
        a_inf     = (a0[W-2:MAN_W] == EMAX) && (a0[MAN_W-1:0] == '0);
        b_inf     = (b0[W-2:MAN_W] == EMAX) && (b0[MAN_W-1:0] == '0);
        a_nan     = (a0[W-2:MAN_W] == EMAX) && (a0[MAN_W-1:0] != '0);
        b_nan     = (b0[W-2:MAN_W] == EMAX) && (b0[MAN_W-1:0] != '0);
        inf_clash = a_inf && b_inf && (a0[W-1] != b0[W-1]);
        spec_n    = a_nan | b_nan | a_inf | b_inf;
        inv_n1    = (a_nan && !a0[MAN_W-1]) || (b_nan && !b0[MAN_W-1]) || inf_clash;
        if (a_nan || b_nan || inf_clash)
            val_n = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};
        else
            val_n = a_inf ? a0 : b0;
        swap = b0[W-2:0] > a0[W-2:0];
        x    = swap ? b0 : a0;
        y    = swap ? a0 : b0;
        ex   = (x[W-2:MAN_W] == '0) ? EXP_W'(1) : x[W-2:MAN_W];
        ey   = (y[W-2:MAN_W] == '0) ? EXP_W'(1) : y[W-2:MAN_W];
        d    = ex - ey;
        mx   = {x[W-2:MAN_W] != '0, x[MAN_W-1:0], 3'b000};
        my   = {y[W-2:MAN_W] != '0, y[MAN_W-1:0], 3'b000};
        wide = {my, {M{1'b0}}} >> d;
        if (32'(d) >= 32'(MAN_W + 3))
            my_al = {{(M-1){1'b0}}, |my};
        else
            my_al = {wide[2*M-1:M+1], wide[M] | (|wide[M-1:0])};
    end

    // S2: add or subtract magnitudes, then normalise without dropping below exponent 1.
    logic sub_op, sign_n;
    logic [M:0] sum;
    logic [E1-1:0] e_in, e_n;
    logic [M-1:0] m_n;
    logic [15:0] lz, lim, sh;
    always_comb begin
        sub_op = s1_sx ^ s1_sy;
        sum    = sub_op ? ({1'b0, s1_mx} - {1'b0, s1_my}) : ({1'b0, s1_mx} + {1'b0, s1_my});
        e_in   = {1'b0, s1_exp};
        lz     = 16'(M);
        for (int i = 0; i < M; i++)
            if (sum[i]) lz = 16'(M - 1 - i);
        lim = 16'(e_in) - 16'd1;
        sh  = (lz > lim) ? lim : lz;
        if (sum[M]) begin
            m_n = {sum[M:2], sum[1] | sum[0]};
            e_n = e_in + E1'(1);
        end else begin
            m_n = sum[M-1:0] << sh;
            e_n = e_in - E1'(sh);
            if (!m_n[M-1]) e_n = '0;
        end
        if (m_n == '0)
            sign_n = sub_op ? (s1_rm == 3'b010) : s1_sx;
        else
            sign_n = s1_sx;
    end

    // S3: round with guard/round/sticky, handle overflow per mode, pack.
    logic g, rb, st, any, up, to_inf, ov_n, uf_n, inv_n, nx_n;
    logic [MAN_W+1:0] mr;
    logic [E1-1:0] ef;
    logic [MAN_W-1:0] frac;
    logic [W-1:0] res_n;
    always_comb begin
        g   = s2_m[2];
        rb  = s2_m[1];
        st  = s2_m[0];
        any = g | rb | st;
        case (s2_rm)
            3'b001:  up = 1'b0;
            3'b010:  up = s2_sign & any;
            3'b011:  up = !s2_sign & any;
            3'b100:  up = g;
            default: up = g & (rb | st | s2_m[3]);
        endcase
        mr   = {1'b0, s2_m[M-1:3]} + (MAN_W+2)'(up);
        ef   = s2_exp;
        frac = mr[MAN_W-1:0];
        if (mr[MAN_W+1]) begin
            ef   = s2_exp + E1'(1);
            frac = '0;
        end else if (s2_exp == '0 && mr[MAN_W]) begin
            ef = E1'(1);
        end
        ov_n = ef >= {1'b0, EMAX};
        case (s2_rm)
            3'b001:  to_inf = 1'b0;
            3'b010:  to_inf = s2_sign;
            3'b011:  to_inf = !s2_sign;
            default: to_inf = 1'b1;
        endcase
        if (ov_n)
            res_n = to_inf ? {s2_sign, EMAX, {MAN_W{1'b0}}}
                           : {s2_sign, EMAX - EXP_W'(1), {MAN_W{1'b1}}};
        else
            res_n = {s2_sign, ef[EXP_W-1:0], frac};
        uf_n  = !ov_n && (ef == '0) && (frac != '0);
        nx_n  = any | ov_n;
        inv_n = 1'b0;
        if (s2_spec) begin
            res_n = s2_val;
            ov_n  = 1'b0;
            uf_n  = 1'b0;
            nx_n  = 1'b0;
            inv_n = s2_inv;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v0 <= 1'b0; a0 <= '0; b0 <= '0; rm0 <= '0;
            v1 <= 1'b0; s1_sx <= 1'b0; s1_sy <= 1'b0; s1_exp <= '0; s1_mx <= '0; s1_my <= '0;
            s1_rm <= '0; s1_spec <= 1'b0; s1_inv <= 1'b0; s1_val <= '0;
            v2 <= 1'b0; s2_sign <= 1'b0; s2_exp <= '0; s2_m <= '0; s2_rm <= '0;
            s2_spec <= 1'b0; s2_inv <= 1'b0; s2_val <= '0;
            out_valid <= 1'b0; fp_result <= '0;
            overflow <= 1'b0; underflow <= 1'b0; invalid <= 1'b0; inexact <= 1'b0;
        end else if (adv) begin
            v0 <= in_valid; a0 <= fp_a; b0 <= b_eff; rm0 <= r_mode;
            v1 <= v0; s1_sx <= x[W-1]; s1_sy <= y[W-1]; s1_exp <= ex; s1_mx <= mx; s1_my <= my_al;
            s1_rm <= rm0; s1_spec <= spec_n; s1_inv <= inv_n1; s1_val <= val_n;
            v2 <= v1; s2_sign <= sign_n; s2_exp <= e_n; s2_m <= m_n; s2_rm <= s1_rm;
            s2_spec <= s1_spec; s2_inv <= s1_inv; s2_val <= s1_val;
            out_valid <= v2; fp_result <= res_n;
            overflow <= ov_n; underflow <= uf_n; invalid <= inv_n; inexact <= nx_n;
        end
    end
endmodule

// File: tb/tb_fp_adder_pipe.sv
// Self-checking bench for fp_adder_pipe (binary32): directed vectors, back-pressure, reset, random integer sums.
module tb_fp_adder_pipe;
    logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
    logic [31:0] fp_a = '0, fp_b = '0, fp_result;
    logic [2:0] r_mode = '0;
`ifdef FP_ADDER_PIPE_SUB_OP_EN
    logic op_sub = 1'b0;
`endif
    logic overflow, underflow, invalid, inexact;
    logic [35:0] exp_q[$];
    logic [35:0] mon_got, mon_want;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    fp_adder_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .fp_a(fp_a), .fp_b(fp_b), .r_mode(r_mode),
`ifdef FP_ADDER_PIPE_SUB_OP_EN
        .op_sub(op_sub),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .fp_result(fp_result),
        .overflow(overflow), .underflow(underflow), .invalid(invalid), .inexact(inexact)
    );

    // Scoreboard: every delivered result is popped against the expectation queue.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            mon_got = {fp_result, overflow, underflow, invalid, inexact};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output got=%h flags(ov,uf,nv,nx)=%b", mon_got[35:4], mon_got[3:0]);
            end else begin
                mon_want = exp_q.pop_front();
                if (mon_got !== mon_want) begin
                    errors++;
                    $display("FAIL result got=%h flags=%b required=%h flags=%b",
                             mon_got[35:4], mon_got[3:0], mon_want[35:4], mon_want[3:0]);
                end
            end
        end
    end

    function automatic logic [31:0] enc(input int mag, input logic sign);
        logic [31:0] m;
        int p;
        if (mag == 0) return {sign, 31'd0};
        m = mag;
        p = 0;
        for (int i = 0; i < 24; i++) if (m[i]) p = i;
        m = m << (23 - p);
        return {sign, 8'(127 + p), m[22:0]};
    endfunction

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm,
                        input logic [35:0] want);
        int n;
        fp_a = a; fp_b = b; r_mode = rm; in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout in_ready=%b required=1", in_ready);
        end else begin
            exp_q.push_back(want);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_latency(input string name);
        int cyc;
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!out_valid && cyc < 10);
        checks++;
        if (cyc != 3) begin
            errors++;
            $display("FAIL %s cycles=%0d required=3", name, cyc);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if (out_valid !== 1'b0 || fp_result !== 32'h0 || {overflow, underflow, invalid, inexact} !== 4'b0) begin
            errors++;
            $display("FAIL reset_outputs valid=%b result=%h flags=%b required 0/0/0",
                     out_valid, fp_result, {overflow, underflow, invalid, inexact});
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got=%b required=1", in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        send(32'h3F800000, 32'h3F800000, 3'd0, {32'h40000000, 4'b0000});
        check_latency("basic_latency");
        drain();
    endtask

    task automatic test_subnormal();
        send(32'h000A0000, 32'h000A0000, 3'd1, {32'h00140000, 4'b0100});
        send(32'h00400000, 32'h00400000, 3'd1, {32'h00800000, 4'b0000});
        drain();
    endtask

    task automatic test_overflow();
        send(32'h7F7FFFFF, 32'h7F7FFFFF, 3'd0, {32'h7F800000, 4'b1001});
        send(32'h7F7FFFFF, 32'h7F7FFFFF, 3'd1, {32'h7F7FFFFF, 4'b1001});
        send(32'hFF7FFFFF, 32'hFF7FFFFF, 3'd3, {32'hFF7FFFFF, 4'b1001});
        send(32'h7F7FFFFF, 32'h7F7FFFFF, 3'd2, {32'h7F7FFFFF, 4'b1001});
        send(32'h7F7FFFFF, 32'h7F7FFFFF, 3'd4, {32'h7F800000, 4'b1001});
        drain();
    endtask

    task automatic test_specials();
        send(32'h7F800000, 32'hFF800000, 3'd0, {32'h7FC00000, 4'b0010});
        send(32'h7F800001, 32'h3F800000, 3'd0, {32'h7FC00000, 4'b0010});
        send(32'h7FC00000, 32'h3F800000, 3'd0, {32'h7FC00000, 4'b0000});
        send(32'hFF800000, 32'h3F800000, 3'd0, {32'hFF800000, 4'b0000});
        send(32'h3F800000, 32'hBF800000, 3'd2, {32'h80000000, 4'b0000});
        send(32'h3F800000, 32'hBF800000, 3'd0, {32'h00000000, 4'b0000});
        send(32'h80000000, 32'h80000000, 3'd0, {32'h80000000, 4'b0000});
        drain();
    endtask

    task automatic test_rounding();
        send(32'h3F800000, 32'h33800000, 3'd0, {32'h3F800000, 4'b0001});
        send(32'h3F800000, 32'h33800000, 3'd3, {32'h3F800001, 4'b0001});
        send(32'h3F800000, 32'h33800000, 3'd4, {32'h3F800001, 4'b0001});
        send(32'h3F800000, 32'h33800000, 3'd5, {32'h3F800000, 4'b0001});
        send(32'h3F800000, 32'h33C00000, 3'd0, {32'h3F800001, 4'b0001});
        send(32'h3F800000, 32'h33C00000, 3'd2, {32'h3F800000, 4'b0001});
        send(32'hBF800000, 32'hB3800000, 3'd2, {32'hBF800001, 4'b0001});
        send(32'h3F800000, 32'hB3800000, 3'd1, {32'h3F7FFFFF, 4'b0000});
        send(32'h40400000, 32'hC0000000, 3'd0, {32'h3F800000, 4'b0000});
        drain();
    endtask

    task automatic test_back_pressure();
        logic [31:0] held;
        logic stall_prev;
        int stalls;
        held = '0;
        stall_prev = 1'b0;
        stalls = 0;
        fork
            begin
                send(32'h40000000, 32'h3F800000, 3'd0, {32'h40400000, 4'b0000});
                send(32'h40400000, 32'h3F800000, 3'd0, {32'h40800000, 4'b0000});
                send(32'h40800000, 32'h3F800000, 3'd0, {32'h40A00000, 4'b0000});
                send(32'h40A00000, 32'h3F800000, 3'd0, {32'h40C00000, 4'b0000});
                send(32'h40C00000, 32'h3F800000, 3'd0, {32'h40E00000, 4'b0000});
            end
            begin
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b1;
            end
            begin
                for (int i = 0; i < 14; i++) begin
                    @(negedge clk);
                    if (out_valid && !out_ready) begin
                        stalls++;
                        checks++;
                        if (in_ready !== 1'b0) begin
                            errors++;
                            $display("FAIL stall_in_ready got=%b required=0", in_ready);
                        end
                        if (stall_prev) begin
                            checks++;
                            if (fp_result !== held) begin
                                errors++;
                                $display("FAIL stall_hold got=%h required=%h", fp_result, held);
                            end
                        end
                        held = fp_result;
                        stall_prev = 1'b1;
                    end else begin
                        stall_prev = 1'b0;
                    end
                end
            end
        join
        checks++;
        if (stalls < 3) begin
            errors++;
            $display("FAIL stall_seen cycles=%0d required>=3", stalls);
        end
        drain();
    endtask

    task automatic test_reset_midflight();
        send(32'h3F800000, 32'h3F800000, 3'd0, {32'h40000000, 4'b0000});
        send(32'h40000000, 32'h3F800000, 3'd0, {32'h40400000, 4'b0000});
        send(32'h40400000, 32'h3F800000, 3'd0, {32'h40800000, 4'b0000});
        @(posedge clk);
        #2;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_valid got=%b required=1", out_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || fp_result !== 32'h0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_reset valid=%b result=%h in_ready=%b required 0/0/1",
                     out_valid, fp_result, in_ready);
        end
        exp_q.delete();
        #5;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL stale_output valid=%b required=0", out_valid);
            end
        end
        @(posedge clk);
        #1;
        send(32'h40000000, 32'h40000000, 3'd0, {32'h40800000, 4'b0000});
        check_latency("post_reset_latency");
        drain();
    endtask

    task automatic test_random();
        int ia, ib, s;
        logic sa, sb, rs;
        logic [2:0] rm;
        bit done;
        done = 1'b0;
        fork
            begin
                for (int k = 0; k < 40; k++) begin
                    ia = $urandom_range(1, 100000);
                    ib = ($urandom_range(0, 4) == 0) ? ia : $urandom_range(1, 100000);
                    sa = 1'($urandom_range(0, 1));
                    sb = 1'($urandom_range(0, 1));
                    rm = 3'($urandom_range(0, 4));
                    s  = (sa ? -ia : ia) + (sb ? -ib : ib);
                    rs = (s == 0) ? (rm == 3'd2) : (s < 0);
                    send(enc(ia, sa), enc(ib, sb), rm, {enc((s < 0) ? -s : s, rs), 4'b0000});
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #1;
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        drain();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_subnormal();
        test_overflow();
        test_specials();
        test_rounding();
        test_back_pressure();
        test_reset_midflight();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
